// File: rtl/hawk_tbl_wr_mngr_if.sv
// Hawk table write manager port bundle:
// request/completion side plus single-beat AXI4 write channels.
interface hawk_tbl_wr_mngr_if #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 4,
  parameter int REQ_ID_W = 11
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_type_i;
  logic [REQ_ID_W-1:0]   req_id_i;
  logic [127:0]          req_entry_i;
  logic [DATA_W-1:0]     req_line_i;
  logic                  done_o;
  logic                  err_o;
  logic [ADDR_W-1:0]     m_awaddr_o;
  logic                  m_awvalid_o;
  logic                  m_awready_i;
  logic [ID_W-1:0]       m_awid_o;
  logic [7:0]            m_awlen_o;
  logic [2:0]            m_awsize_o;
  logic [1:0]            m_awburst_o;
  logic [DATA_W-1:0]     m_wdata_o;
  logic [DATA_W/8-1:0]   m_wstrb_o;
  logic                  m_wlast_o;
  logic                  m_wvalid_o;
  logic                  m_wready_i;
  logic                  m_bvalid_i;
  logic [1:0]            m_bresp_i;
  logic [ID_W-1:0]       m_bid_i;
  logic                  m_bready_o;

  modport master (
    input  req_valid_i, req_type_i, req_id_i,
    input  req_entry_i, req_line_i,
    output req_ready_o, done_o, err_o,
    output m_awaddr_o, m_awvalid_o, m_awid_o,
    output m_awlen_o, m_awsize_o, m_awburst_o,
    input  m_awready_i,
    output m_wdata_o, m_wstrb_o, m_wlast_o,
    output m_wvalid_o,
    input  m_wready_i,
    input  m_bvalid_i, m_bresp_i, m_bid_i,
    output m_bready_o
  );

  modport slave (
    output req_valid_i, req_type_i, req_id_i,
    output req_entry_i, req_line_i,
    input  req_ready_o, done_o, err_o,
    input  m_awaddr_o, m_awvalid_o, m_awid_o,
    input  m_awlen_o, m_awsize_o, m_awburst_o,
    output m_awready_i,
    input  m_wdata_o, m_wstrb_o, m_wlast_o,
    input  m_wvalid_o,
    output m_wready_i,
    output m_bvalid_i, m_bresp_i, m_bid_i,
    input  m_bready_o
  );
endinterface

// File: rtl/hawk_tbl_wr_mngr.sv
// Hawk table write manager: merges one ATT/list entry into
// its cacheline and writes it back with one AXI4 beat.
module hawk_tbl_wr_mngr #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 512,
  parameter int ID_W          = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0,
  parameter int ATT_ENTRY_MAX = 1024,
  parameter int LST_ENTRY_MAX = 256,
  parameter logic [ADDR_W-1:0] ATT_BASE = 'h1000_0000,
  parameter logic [ADDR_W-1:0] LST_BASE = 'h2000_0000
) (
  input logic clk_i,
  input logic rst_i,
  hawk_tbl_wr_mngr_if.master bus
);

  localparam int ATT_ID_W = $clog2(ATT_ENTRY_MAX + 1);
  localparam int LST_ID_W = $clog2(LST_ENTRY_MAX + 1);

  typedef enum logic [1:0] {
    IDLE, ADDR_DATA, RESP, DONE
  } state_e;

  state_e              state, state_n;
  logic                aw_pend, w_pend, err;
  logic [ADDR_W-1:0]   awaddr_q, addr_n;
  logic [DATA_W-1:0]   wdata_q, line_n;
  logic [ATT_ID_W-1:0] k_att;
  logic [LST_ID_W-1:0] k_lst;
  logic                accept, id_zero;
  logic                aw_ok, w_ok;
  logic                unused_bid;

  assign unused_bid = ^bus.m_bid_i;

  assign accept  = bus.req_valid_i && (state == IDLE);
  assign id_zero = (bus.req_id_i == '0);
  assign aw_ok   = !aw_pend || bus.m_awready_i;
  assign w_ok    = !w_pend || bus.m_wready_i;

  // Slot selection and line merge from the 0-based entry index
  always_comb begin
    k_att  = bus.req_id_i[ATT_ID_W-1:0] - ATT_ID_W'(1);
    k_lst  = bus.req_id_i[LST_ID_W-1:0] - LST_ID_W'(1);
    line_n = bus.req_line_i;
    addr_n = '0;
    if (bus.req_type_i) begin
      addr_n = LST_BASE + (ADDR_W'(k_lst >> 2) << 6);
      line_n[128*k_lst[1:0] +: 128] = bus.req_entry_i;
    end else begin
      addr_n = ATT_BASE + (ADDR_W'(k_att >> 3) << 6);
      line_n[64*k_att[2:0] +: 64] = bus.req_entry_i[63:0];
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if (accept) state_n = id_zero ? DONE : ADDR_DATA;
      ADDR_DATA: if (aw_ok && w_ok) state_n = RESP;
      RESP:      if (bus.m_bvalid_i) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Request capture, per-channel pending flags and error status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      err      <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      if (accept) begin
        awaddr_q <= addr_n;
        wdata_q  <= line_n;
        err      <= id_zero;
        aw_pend  <= !id_zero;
        w_pend   <= !id_zero;
      end
      if (state == ADDR_DATA) begin
        if (bus.m_awready_i) aw_pend <= 1'b0;
        if (bus.m_wready_i)  w_pend  <= 1'b0;
      end
      if (state == RESP && bus.m_bvalid_i)
        err <= (bus.m_bresp_i != 2'b00);
    end
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.done_o      = (state == DONE);
  assign bus.err_o       = (state == DONE) && err;
  assign bus.m_awaddr_o  = awaddr_q;
  assign bus.m_awvalid_o = (state == ADDR_DATA) && aw_pend;
  assign bus.m_awid_o    = AXI_ID;
  assign bus.m_awlen_o   = 8'd0;
  assign bus.m_awsize_o  = 3'd6;
  assign bus.m_awburst_o = 2'b01;
  assign bus.m_wdata_o   = wdata_q;
  assign bus.m_wstrb_o   = '1;
  assign bus.m_wlast_o   = 1'b1;
  assign bus.m_wvalid_o  = (state == ADDR_DATA) && w_pend;
  assign bus.m_bready_o  = (state == RESP);

endmodule

// File: tb/tb_hawk_tbl_wr_mngr.sv
// Bench for hawk_tbl_wr_mngr: directed and random writes
// against a table-layout reference model.
module tb_hawk_tbl_wr_mngr;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W = 4;
  localparam int ATT_MAX = 1024;
  localparam int LST_MAX = 256;
  localparam int REQ_ID_W = 11;
  localparam logic [63:0] ATT_B = 64'h1000_0000;
  localparam logic [63:0] LST_B = 64'h2000_0000;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hawk_tbl_wr_mngr_if #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .ID_W(ID_W), .REQ_ID_W(REQ_ID_W)
  ) bus ();

  hawk_tbl_wr_mngr #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
    .AXI_ID(4'd0),
    .ATT_ENTRY_MAX(ATT_MAX), .LST_ENTRY_MAX(LST_MAX),
    .ATT_BASE(ATT_B), .LST_BASE(LST_B)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] ref_line(
    input bit typ, input int id,
    input logic [127:0] e, input logic [511:0] l);
    logic [511:0] r;
    int k;
    r = l;
    k = id - 1;
    if (typ)
      for (int i = 0; i < 128; i++) r[128*(k%4)+i] = e[i];
    else
      for (int i = 0; i < 64; i++) r[64*(k%8)+i] = e[i];
    return r;
  endfunction

  function automatic logic [63:0] ref_addr(
    input bit typ, input int id);
    int k;
    k = id - 1;
    if (typ) return LST_B + 64'(k / 4) * 64;
    return ATT_B + 64'(k / 8) * 64;
  endfunction

  function automatic logic [511:0] rnd_line();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_axi();
    bus.m_awready_i = 1'b0;
    bus.m_wready_i  = 1'b0;
    bus.m_bvalid_i  = 1'b0;
    bus.m_bresp_i   = 2'b00;
    bus.m_bid_i     = '0;
  endtask

  // Runs one request from the negedge before accept to done_o.
  task automatic do_write(input string tag, input bit typ,
                          input int id, input logic [127:0] e,
                          input logic [511:0] l, input int awd,
                          input int wd, input logic [1:0] rsp);
    logic [511:0] el;
    logic [63:0] ea;
    bit aw_hs, w_hs, got_done, exp_err;
    int exp_cyc, m;
    el = ref_line(typ, id, e, l);
    ea = ref_addr(typ, id);
    exp_err = (id == 0) || (rsp != 2'b00);
    m = (awd > wd) ? awd : wd;
    if (m < 1) m = 1;
    exp_cyc = (id == 0) ? 1 : m + 2;
    aw_hs = 0;
    w_hs = 0;
    got_done = 0;
    chk({tag, " ready"}, bus.req_ready_o, 1'b1);
    bus.req_valid_i = 1'b1;
    bus.req_type_i  = typ;
    bus.req_id_i    = REQ_ID_W'(id);
    bus.req_entry_i = e;
    bus.req_line_i  = l;
    idle_axi();
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_line_i  = rnd_line();
    bus.req_entry_i = {$urandom, $urandom, $urandom, $urandom};
    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      if (bus.done_o) begin
        got_done = 1;
        chk({tag, " latency"}, cyc, exp_cyc);
        chk({tag, " err"}, bus.err_o, exp_err);
        chk({tag, " valids_in_done"},
            {bus.m_awvalid_o, bus.m_wvalid_o}, 2'b00);
      end else begin
        chk({tag, " awvalid"}, bus.m_awvalid_o, !aw_hs);
        chk({tag, " wvalid"}, bus.m_wvalid_o, !w_hs);
        chk({tag, " bready"}, bus.m_bready_o, aw_hs && w_hs);
        if (bus.m_awvalid_o) begin
          chk({tag, " awaddr"}, bus.m_awaddr_o, ea);
          chk({tag, " aw_const"},
              {bus.m_awid_o, bus.m_awlen_o, bus.m_awsize_o,
               bus.m_awburst_o},
              {4'd0, 8'd0, 3'd6, 2'b01});
        end
        if (bus.m_wvalid_o) begin
          chk({tag, " wdata"}, bus.m_wdata_o, el);
          chk({tag, " w_const"},
              {bus.m_wstrb_o == '1, bus.m_wlast_o}, 2'b11);
        end
        bus.m_awready_i = (cyc >= awd);
        bus.m_wready_i  = (cyc >= wd);
        bus.m_bvalid_i  = bus.m_bready_o;
        bus.m_bresp_i   = rsp;
        bus.m_bid_i     = 4'($urandom);
        if (bus.m_awvalid_o && bus.m_awready_i) aw_hs = 1;
        if (bus.m_wvalid_o && bus.m_wready_i) w_hs = 1;
        @(negedge clk);
      end
    end
    chk({tag, " done_seen"}, got_done, 1'b1);
    idle_axi();
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] e;
    bit typ;
    int id;
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_type_i  = 1'b0;
    bus.req_id_i    = '0;
    bus.req_entry_i = '0;
    bus.req_line_i  = '0;
    idle_axi();
    repeat (3) @(negedge clk);
    chk("rst ready", bus.req_ready_o, 1'b1);
    chk("rst done_err", {bus.done_o, bus.err_o}, 2'b00);
    chk("rst valids",
        {bus.m_awvalid_o, bus.m_wvalid_o, bus.m_bready_o}, 3'b000);
    chk("rst awaddr", bus.m_awaddr_o, 64'd0);
    chk("rst wdata", bus.m_wdata_o, 512'd0);
    rst = 1'b0;
    @(negedge clk);

    do_write("att1", 0, 1, 128'hDEAD_BEEF, '0, 0, 0, 2'b00);
    do_write("att10", 0, 10, {$urandom, $urandom, $urandom, $urandom},
             '1, 0, 0, 2'b00);
    do_write("lst4", 1, 4, {$urandom, $urandom, $urandom, $urandom},
             rnd_line(), 0, 0, 2'b00);
    do_write("lst5", 1, 5, {$urandom, $urandom, $urandom, $urandom},
             rnd_line(), 0, 0, 2'b00);
    do_write("aw_slow", 0, 77, {$urandom, $urandom, $urandom, $urandom},
             rnd_line(), 5, 0, 2'b00);
    do_write("w_slow", 1, 200, {$urandom, $urandom, $urandom, $urandom},
             rnd_line(), 0, 4, 2'b00);
    do_write("bresp_slverr", 0, 1024, 128'h1234, rnd_line(),
             0, 0, 2'b10);
    do_write("id0", 0, 0, 128'h55, rnd_line(), 0, 0, 2'b00);
    do_write("lst_max", 1, LST_MAX, {$urandom, $urandom, $urandom,
             $urandom}, rnd_line(), 2, 2, 2'b00);

    // reset while waiting for the write response
    bus.req_valid_i = 1'b1;
    bus.req_type_i  = 1'b0;
    bus.req_id_i    = REQ_ID_W'(3);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.m_awready_i = 1'b1;
    bus.m_wready_i  = 1'b1;
    @(negedge clk);
    chk("rstmid in_resp", bus.m_bready_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid valids",
        {bus.m_awvalid_o, bus.m_wvalid_o, bus.m_bready_o}, 3'b000);
    chk("rstmid ready", bus.req_ready_o, 1'b1);
    chk("rstmid done", bus.done_o, 1'b0);
    rst = 1'b0;
    idle_axi();
    @(negedge clk);
    chk("rstmid no_done", bus.done_o, 1'b0);
    chk("rstmid ready2", bus.req_ready_o, 1'b1);

    for (int n = 0; n < 25; n++) begin
      typ = 1'($urandom);
      id = typ ? int'($urandom_range(1, LST_MAX))
               : int'($urandom_range(1, ATT_MAX));
      e = {$urandom, $urandom, $urandom, $urandom};
      do_write($sformatf("rnd%0d", n), typ, id, e, rnd_line(),
               int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
